imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL expose parameter DEPTH, default 256, giving the maximum number of 16-bit instruction words accepted.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port rx_valid  input  1  byte-stream source has a byte on rx_data.
REQ-005 Port rx_data  input  8  byte-stream payload.
REQ-006 Port rx_ready  output  1  loader can accept a byte this cycle.
REQ-007 Port imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-008 Port imem_addr  output  16  byte address of the word written; always even.
REQ-009 Port imem_wdata  output  16  instruction word written.
REQ-010 Port core_reset  output  1  holds the 16-bit core in reset until the load completes.
REQ-011 Port load_done  output  1  image loaded and verified.
REQ-012 Port err  output  1  image rejected.

Function
REQ-013 The loader SHALL accept a byte only on a rising clk edge where rx_valid and rx_ready are both 1.
REQ-014 The stream format SHALL be: count N (2 bytes, high byte first), then N words (2 bytes each, high byte first), then one checksum byte.
REQ-015 The checksum SHALL equal the XOR of every preceding byte in the stream, including both count bytes.
REQ-016 The FSM SHALL have the states CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE and ERR, and SHALL enter CNT_HI on reset.
REQ-017 rx_ready SHALL be 1 in CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHK, and 0 in WRITE, DONE and ERR.
REQ-018 Accepting a byte SHALL cause these transitions: CNT_HI->CNT_LO, DATA_HI->DATA_LO, DATA_LO->WRITE.
REQ-019 On the CNT_LO byte the FSM SHALL go to CHK if N==0, to ERR if N>DEPTH, and to DATA_HI otherwise.
REQ-020 WRITE SHALL last exactly one cycle, with imem_we=1, imem_addr={idx[14:0],1'b0} and imem_wdata={hi,lo}.
REQ-021 In WRITE, idx SHALL then increment, and the FSM SHALL go to CHK if idx+1==N, else to DATA_HI.
REQ-022 On the CHK byte the FSM SHALL go to DONE if the byte equals the running XOR, else to ERR.
REQ-023 DONE and ERR SHALL be terminal; only reset leaves them.
REQ-024 imem_we SHALL be 0 in every state except WRITE.
REQ-025 imem_addr and imem_wdata SHALL hold their last written values outside WRITE.
REQ-026 core_reset SHALL be 1 in every state except DONE, where it SHALL be 0.
REQ-027 load_done SHALL be 1 only in DONE, and err SHALL be 1 only in ERR.
REQ-028 load_done or err SHALL assert in the cycle after the checksum byte is accepted.
REQ-029 An idle gap (rx_valid=0) of any length in any receiving state SHALL leave state, idx and the running XOR unchanged.
REQ-030 idx SHALL be DEPTH_LOG2+1 bits wide, and N SHALL be compared as a 16-bit unsigned value.

Reset
REQ-031 While reset is 1, outputs SHALL be: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, err=0.
REQ-032 Reset SHALL clear state, idx, N, the byte latch and the running XOR asynchronously.
REQ-033 Reset asserted mid-load SHALL abort the load without a further write; the next stream SHALL start at imem_addr 0.

Verification
REQ-034 Scenario "normal load": bytes 00 02 20 83 41 05 E5 -> two write pulses, (addr 0x0000, data 0x2083) then (addr 0x0002, data 0x4105); load_done=1 and core_reset=0 the cycle after E5.
REQ-035 Scenario "bad checksum": same stream ending in E4 -> two writes occur, then err=1, core_reset stays 1, rx_ready=0.
REQ-036 Scenario "empty image": bytes 00 00 00 -> no imem_we pulses; load_done=1.
REQ-037 Scenario "oversize": with DEPTH=256, bytes 01 01 -> err=1 the cycle after the second byte; further bytes are not accepted.
REQ-038 Scenario "gapped stream": the normal-load stream with random rx_valid=0 gaps of 0-5 cycles -> results identical to REQ-034.
REQ-039 Scenario "reset mid-load": reset after bytes 00 02 20, then the full normal-load stream -> the first write is at addr 0x0000 with data 0x2083; load_done=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot image loader.
// The loader sits on the slave side; whatever feeds bytes and watches the writes uses master.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        core_reset;
  logic        load_done;
  logic        err;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset, load_done, err
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_reset, load_done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a counted big-endian word image from a byte stream, writes it into
// instruction memory and releases the core only when the trailing XOR checksum matches.
//
// state   | meaning
// CNT_HI  | waiting for the high byte of the word count
// CNT_LO  | waiting for the low byte of the word count
// DATA_HI | waiting for the high byte of the next word
// DATA_LO | waiting for the low byte of the next word
// WRITE   | one-cycle write strobe to instruction memory
// CHK     | waiting for the checksum byte
// DONE    | image accepted, core released (terminal)
// ERR     | image rejected (terminal)
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam int             IW      = $clog2(DEPTH) + 1;
  localparam logic [16:0]    DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR
  } state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [15:0]   n_q;
  logic [7:0]    hi_q;
  logic [7:0]    xor_q;
  logic          we_q;
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          done_q;
  logic          err_q;
  logic          core_reset_q;

  logic          accept;
  logic [15:0]   n_d;
  logic [15:0]   idx_ext;
  logic [16:0]   idx_inc;

  // Ready is a pure state decode so it is available the first cycle after reset releases.
  assign bus.rx_ready = ~reset & (state_q inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK});
  assign accept       = bus.rx_valid & bus.rx_ready;
  assign n_d          = {hi_q, bus.rx_data};
  assign idx_ext      = 16'(idx_q);
  assign idx_inc      = {1'b0, idx_ext} + 17'd1;

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_reset = core_reset_q;
  assign bus.load_done  = done_q;
  assign bus.err        = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CNT_HI;
      idx_q        <= '0;
      n_q          <= '0;
      hi_q         <= '0;
      xor_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        CNT_HI: begin
          if (accept) begin
            hi_q    <= bus.rx_data;
            xor_q   <= xor_q ^ bus.rx_data;
            state_q <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            n_q   <= n_d;
            xor_q <= xor_q ^ bus.rx_data;
            if (n_d == 16'd0) begin
              state_q <= CHK;
            end else if ({1'b0, n_d} > DEPTH_W) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_q    <= bus.rx_data;
            xor_q   <= xor_q ^ bus.rx_data;
            state_q <= DATA_LO;
          end
        end
        DATA_LO: begin
          // Address and data are loaded together with the strobe so they stay valid afterwards.
          if (accept) begin
            xor_q   <= xor_q ^ bus.rx_data;
            we_q    <= 1'b1;
            addr_q  <= {idx_ext[14:0], 1'b0};
            wdata_q <= {hi_q, bus.rx_data};
            state_q <= WRITE;
          end
        end
        WRITE: begin
          idx_q   <= idx_q + IW'(1);
          state_q <= (idx_inc == {1'b0, n_q}) ? CHK : DATA_HI;
        end
        CHK: begin
          if (accept) begin
            if (bus.rx_data == xor_q) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              core_reset_q <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        DONE: ;
        ERR:  ;
        default: state_q <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader with a positional stream model and literal scenario checks.
module tb_imem_loader;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset;
  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stream[$];
  logic [15:0] wlog_addr[$];
  logic [15:0] wlog_data[$];

  // Model: position k in the stream decides everything.
  int          k;
  bit          wp;
  bit          term;
  bit          ok;
  int          n_cnt;
  logic [7:0]  xr;
  logic [15:0] exp_addr;
  logic [15:0] exp_data;

  always @(negedge clk) begin
    if (!reset && bus.imem_we) begin
      wlog_addr.push_back(bus.imem_addr);
      wlog_data.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] wa(input int i);
    return (i < wlog_addr.size()) ? wlog_addr[i] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] wd(input int i);
    return (i < wlog_data.size()) ? wlog_data[i] : 16'hDEAD;
  endfunction

  task automatic model_reset();
    k = 0; wp = 0; term = 0; ok = 0; n_cnt = 0; xr = 8'h00;
    exp_addr = 16'h0000; exp_data = 16'h0000;
  endtask

  task automatic accept_byte(input logic [7:0] b);
    if (k == 1) begin
      n_cnt = {stream[0], b};
      if (n_cnt > DEPTH) begin term = 1; ok = 0; end
    end else if (k >= 2 && k < 2 + 2 * n_cnt) begin
      if ((k % 2) == 1) begin
        wp = 1;
        exp_addr = 16'(k - 3);
        exp_data = {stream[k-1], b};
      end
    end else if (k == 2 + 2 * n_cnt) begin
      term = 1;
      ok = (b == xr);
    end
    xr ^= b;
    k++;
  endtask

  task automatic compare_all();
    check("rx_ready",   32'(bus.rx_ready),   32'(!wp && !term));
    check("imem_we",    32'(bus.imem_we),    32'(wp));
    check("imem_addr",  32'(bus.imem_addr),  32'(exp_addr));
    check("imem_wdata", 32'(bus.imem_wdata), 32'(exp_data));
    check("load_done",  32'(bus.load_done),  32'(term && ok));
    check("err",        32'(bus.err),        32'(term && !ok));
    check("core_reset", 32'(bus.core_reset), 32'(!(term && ok)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    reset = 1'b1;
    #1;
    check("rst_rx_ready",   32'(bus.rx_ready),   0);
    check("rst_imem_we",    32'(bus.imem_we),    0);
    check("rst_imem_addr",  32'(bus.imem_addr),  0);
    check("rst_imem_wdata", 32'(bus.imem_wdata), 0);
    check("rst_core_reset", 32'(bus.core_reset), 1);
    check("rst_load_done",  32'(bus.load_done),  0);
    check("rst_err",        32'(bus.err),        0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    model_reset();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  task automatic run_stream(input int gap_max, input int abort_at, input int budget);
    int gap;
    int post;
    bit v;
    logic [7:0] d;
    gap  = $urandom_range(0, gap_max);
    post = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      compare_all();
      if (abort_at >= 0 && k == abort_at && !wp) begin
        bus.rx_valid = 1'b0;
        return;
      end
      if (term) begin
        if (post == 4) return;
        post++;
      end
      if (gap > 0) begin v = 0; gap--; end
      else v = 1;
      d = (k < stream.size()) ? stream[k] : 8'($urandom);
      bus.rx_valid = v;
      bus.rx_data  = d;
      @(posedge clk);
      if (wp) wp = 0;
      else if (v && !term && k < stream.size()) begin
        accept_byte(d);
        gap = $urandom_range(0, gap_max);
      end
    end
    check("stream_completed_in_budget", 32'(term), 1);
  endtask

  task automatic make_stream(input int n, input bit corrupt);
    logic [7:0]  x;
    logic [15:0] w;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
      end
    end
    x = 8'h00;
    foreach (stream[i]) x ^= stream[i];
    stream.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
  endtask

  task automatic check_normal(input string tag);
    check({tag, "_writes"}, wlog_addr.size(), 2);
    check({tag, "_addr0"},  32'(wa(0)), 32'h0000);
    check({tag, "_data0"},  32'(wd(0)), 32'h2083);
    check({tag, "_addr1"},  32'(wa(1)), 32'h0002);
    check({tag, "_data1"},  32'(wd(1)), 32'h4105);
    check({tag, "_load_done"},  32'(bus.load_done),  1);
    check({tag, "_core_reset"}, 32'(bus.core_reset), 0);
  endtask

  initial begin
    int n;
    bit corrupt;
    int gmax;
    int abort_at;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    do_reset();

    stream = '{8'h00, 8'h02, 8'h20, 8'h83, 8'h41, 8'h05, 8'hE5};
    run_stream(0, -1, 200);
    check_normal("normal");

    do_reset();
    stream = '{8'h00, 8'h02, 8'h20, 8'h83, 8'h41, 8'h05, 8'hE4};
    run_stream(0, -1, 200);
    check("badchk_writes",     wlog_addr.size(), 2);
    check("badchk_err",        32'(bus.err),        1);
    check("badchk_core_reset", 32'(bus.core_reset), 1);
    check("badchk_rx_ready",   32'(bus.rx_ready),   0);
    check("badchk_load_done",  32'(bus.load_done),  0);

    do_reset();
    stream = '{8'h00, 8'h00, 8'h00};
    run_stream(0, -1, 100);
    check("empty_writes",    wlog_addr.size(), 0);
    check("empty_load_done", 32'(bus.load_done), 1);

    do_reset();
    stream = '{8'h01, 8'h01};
    run_stream(0, -1, 100);
    check("oversize_err",      32'(bus.err),      1);
    check("oversize_rx_ready", 32'(bus.rx_ready), 0);
    check("oversize_writes",   wlog_addr.size(),  0);

    do_reset();
    stream = '{8'h00, 8'h02, 8'h20, 8'h83, 8'h41, 8'h05, 8'hE5};
    run_stream(5, -1, 300);
    check_normal("gapped");

    do_reset();
    run_stream(0, 3, 100);
    do_reset();
    run_stream(2, -1, 300);
    check_normal("after_abort");

    do_reset();
    make_stream(DEPTH, 0);
    run_stream(0, -1, 3000);
    check("full_load_done", 32'(bus.load_done), 1);
    check("full_writes",    wlog_addr.size(), DEPTH);
    check("full_last_addr", 32'(wa(DEPTH - 1)), 32'(2 * (DEPTH - 1)));

    do_reset();
    make_stream(DEPTH + 1, 0);
    run_stream(0, -1, 100);
    check("depth_plus1_err", 32'(bus.err), 1);

    do_reset();
    make_stream(16'hFFFF, 0);
    run_stream(1, -1, 100);
    check("ffff_err", 32'(bus.err), 1);

    for (int it = 0; it < 40; it++) begin
      do_reset();
      n       = $urandom_range(0, 8);
      corrupt = ($urandom_range(0, 3) == 0);
      gmax    = $urandom_range(0, 5);
      make_stream(n, corrupt);
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, stream.size() - 1)) : -1;
      run_stream(gmax, abort_at, 600);
      if (abort_at < 0) check("rand_write_count", wlog_addr.size(), n);
    end

    do_reset();
    stream = '{8'h00, 8'h02, 8'h20, 8'h83, 8'h41, 8'h05, 8'hE5};
    run_stream(3, -1, 300);
    check_normal("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
